// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game session logic.
//   state_e      : session state (IDLE, PLAY, OVER)
//   BCD_DIGITS   : number of BCD digits in the score
//   SCORE_MAX    : saturation value of the score
//   bcd_digit_add: single-digit BCD add with carry-out
// ---------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_e;

    localparam int          BCD_DIGITS = 4;
    localparam logic [15:0] SCORE_MAX  = 16'h9999;

    typedef struct packed {
        logic       carry;
        logic [3:0] digit;
    } digit_sum_t;

    // Adds 0..2 to one BCD digit (0..9); the result wraps past 9 with carry.
    function automatic digit_sum_t bcd_digit_add(input logic [3:0] d, input logic [1:0] add);
        logic [4:0] t;
        digit_sum_t r;
        t = {1'b0, d} + {3'b000, add};
        if (t > 5'd9) begin
            r.carry = 1'b1;
            r.digit = 4'(t - 5'd10);
        end else begin
            r.carry = 1'b0;
            r.digit = t[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_inc.sv
// ---------------------------------------------------------------------------
// bcd_inc
// Combinational saturating increment of a 4-digit BCD value.
// Ports:
//   value_i [15:0] : current BCD value, [15:12] is thousands
//   inc_i   [1:0]  : amount to add (1 or 2)
//   sum_o   [15:0] : value_i + inc_i, clamped at 9999
// ---------------------------------------------------------------------------
module bcd_inc
    import game_pkg::*;
(
    input  logic [15:0] value_i,
    input  logic [1:0]  inc_i,
    output logic [15:0] sum_o
);

    logic [15:0] raw_s;
    logic [1:0]  carry_s;
    digit_sum_t  digit_s;

    // Ripple the increment through the digits; a carry out of the top digit saturates.
    always_comb begin
        raw_s   = 16'h0000;
        carry_s = inc_i;
        digit_s = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            digit_s            = bcd_digit_add(value_i[4*i +: 4], carry_s);
            raw_s[4*i +: 4]    = digit_s.digit;
            carry_s            = {1'b0, digit_s.carry};
        end
        if (carry_s != 2'd0) begin
            sum_o = SCORE_MAX;
        end else begin
            sum_o = raw_s;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
// Converts the judge's level-held hit/miss into single scoring events and runs
// the IDLE -> PLAY -> OVER game session with a BCD score, streak bonus and lives.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start                 : level, begins a fresh session from IDLE or OVER
//   hit, miss             : judge levels; only 0->1 edges seen in PLAY count
//   score_bcd [15:0]      : 4-digit BCD score
//   lives [3:0]           : remaining lives
//   streak [3:0]          : consecutive hits, saturating at 15
//   playing, game_over    : session state flags
//   hit_pulse, miss_pulse : one-cycle strobes per counted event
// ---------------------------------------------------------------------------
module score_keeper
    import game_pkg::*;
#(
    parameter int LIVES_INIT = 3,
    parameter int STREAK_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hit,
    input  logic        miss,
    output logic [15:0] score_bcd,
    output logic [3:0]  lives,
    output logic [3:0]  streak,
    output logic        playing,
    output logic        game_over,
    output logic        hit_pulse,
    output logic        miss_pulse
);

    localparam logic [3:0] LIVES_INIT_C = 4'(LIVES_INIT);
    localparam logic [3:0] STREAK_LEN_C = 4'(STREAK_LEN);

    state_e      state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [3:0]  lives_q, lives_d;
    logic [3:0]  streak_q, streak_d;
    logic        hit_prev_q, hit_prev_d;
    logic        miss_prev_q, miss_prev_d;
    logic        hit_pulse_q, hit_pulse_d;
    logic        miss_pulse_q, miss_pulse_d;
    logic        playing_q, playing_d;
    logic        game_over_q, game_over_d;

    logic        hit_ev_s;
    logic        miss_ev_s;
    logic [3:0]  streak_next_s;
    logic [1:0]  inc_s;
    logic [15:0] score_inc_s;

    // Rising-edge events and the streak/bonus increment for a potential hit.
    always_comb begin
        hit_ev_s  = hit  & ~hit_prev_q;
        miss_ev_s = miss & ~miss_prev_q;
        if (streak_q == 4'd15) begin
            streak_next_s = 4'd15;
        end else begin
            streak_next_s = streak_q + 4'd1;
        end
        if (streak_next_s > STREAK_LEN_C) begin
            inc_s = 2'd2;
        end else begin
            inc_s = 2'd1;
        end
    end

    bcd_inc u_bcd_inc (
        .value_i (score_q),
        .inc_i   (inc_s),
        .sum_o   (score_inc_s)
    );

    // Session state machine and next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        lives_d      = lives_q;
        streak_d     = streak_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        // Edge history tracks the inputs in every state, so a level already
        // high when PLAY is entered never looks like a fresh edge.
        hit_prev_d   = hit;
        miss_prev_d  = miss;

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d  = PLAY;
                    score_d  = 16'h0000;
                    lives_d  = LIVES_INIT_C;
                    streak_d = 4'd0;
                end else begin
                    state_d  = state_q;
                end
            end
            PLAY: begin
                // A miss in the same cycle as a hit wins; the hit is dropped.
                if (miss_ev_s) begin
                    streak_d     = 4'd0;
                    lives_d      = lives_q - 4'd1;
                    miss_pulse_d = 1'b1;
                    if (lives_q == 4'd1) begin
                        state_d = OVER;
                    end else begin
                        state_d = PLAY;
                    end
                end else if (hit_ev_s) begin
                    streak_d    = streak_next_s;
                    score_d     = score_inc_s;
                    hit_pulse_d = 1'b1;
                end else begin
                    state_d = PLAY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        playing_d   = (state_d == PLAY);
        game_over_d = (state_d == OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            score_q      <= 16'h0000;
            lives_q      <= 4'd0;
            streak_q     <= 4'd0;
            hit_prev_q   <= 1'b0;
            miss_prev_q  <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            streak_q     <= streak_d;
            hit_prev_q   <= hit_prev_d;
            miss_prev_q  <= miss_prev_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            playing_q    <= playing_d;
            game_over_q  <= game_over_d;
        end
    end

    assign score_bcd  = score_q;
    assign lives      = lives_q;
    assign streak     = streak_q;
    assign playing    = playing_q;
    assign game_over  = game_over_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;

endmodule
